regfile_writeback: RTL and testbench
====================================

# regfile_writeback

In-order writeback stage of the core, between the execute/ALU result path and the register file write port. It accepts destination/result pairs from execute, holds them in a small in-order retire queue, and merges late load data from the memory interface into the matching queue entry. It retires one entry per cycle to the register file, suppresses writes to x0, and publishes a pending-write mask that decode and execute use for hazard detection.

## Interface
- n_regs_p, 32: number of architectural registers; address width aw = $clog2(n_regs_p)
- wd_regs_p, 32: register/data width
- q_depth_p, 4: retire queue entries; power of two, ≥2
- clk  in  1  clock; all state updates on the rising edge
- rst  in  1  reset. One clock; reset is asynchronous and active-high.
- i_ex_valid  in  1  execute presents a retiring op
- o_ex_ready  out  1  queue can accept; high when occupancy < q_depth_p
- i_ex_rdest  in  aw  destination register
- i_ex_result  in  wd_regs_p  ALU/branch-link result; ignored when i_ex_is_load = 1
- i_ex_is_load  in  1  result arrives later on i_ld_*
- i_ld_valid  in  1  load data returns; one pulse per load, in program order
- i_ld_data  in  wd_regs_p  load data
- o_wr_en  out  1  register file write strobe
- o_wr_addr  out  aw  register file write address
- o_wr_data  out  wd_regs_p  register file write data
- o_pending  out  n_regs_p  bit r = 1 while a queued entry targets register r (bit 0 always 0)
- o_ld_err  out  1  sticky: load data arrived with no outstanding load entry
- o_instret  out  64  count of retired entries, including x0-targeted ones

## Operation
- Each queue entry stores rdest, data, is_load, data_ok. The queue is a circular buffer with wr_ptr, rd_ptr, and a ld_ptr for the oldest load still waiting for data. Each pointer is $clog2(q_depth_p)+1 bits, and the MSB is used to separate full from empty.
- Push when i_ex_valid & o_ex_ready. A non-load entry is pushed with data_ok = 1 and data = i_ex_result. A load entry is pushed with data_ok = 0.
- Load fill: when i_ld_valid is high, the oldest valid entry with is_load & !data_ok takes i_ld_data and sets data_ok. ld_ptr then advances to the next such entry, or to wr_ptr if there is none.
- If i_ld_valid is high while no such entry exists, set o_ld_err and discard the data.
- A load pushed and filled in the same cycle is not possible. Data for a load can only arrive in a cycle after the load has been pushed.
- Retire: the head entry is valid with data_ok = 1. The entry pops at the clock edge. o_instret increments.
- o_wr_en = retire & (rdest != 0). o_wr_addr and o_wr_data are taken from the head entry (combinational from queue state).
- Push and pop may occur in the same cycle. ready is based on occupancy before the pop, so a full queue does not accept a push even when it retires in that cycle.
- A fill and a retire may occur in the same cycle on different entries. A fill of the head entry retires on the next cycle (no bypass).
- o_pending is the OR over valid entries of a one-hot decode of rdest, with bit 0 forced to 0. It is combinational from the queue.

## Timing
- Reset values: all pointers 0, queue empty, o_ex_ready = 1, o_wr_en = 0, o_wr_addr = 0, o_wr_data = 0, o_pending = 0, o_ld_err = 0, o_instret = 0.
- ALU result accepted in cycle N, queue otherwise empty: o_wr_en high in cycle N+1.
- Load data pulse in cycle M, with the load at the head: o_wr_en high in cycle M+1.
- Throughput: one retire per cycle.
- A stalled head load blocks all younger entries (strict in-order).
- Asserting rst mid-operation immediately empties the queue. All outputs return to their reset values asynchronously. No partial write is issued after reset is asserted.
- Pointer wrap: pointers wrap modulo 2·q_depth_p. Full is indicated when the indices are equal and the MSBs differ.

## Test plan
- ALU path: push rdest=5, result=0xDEADBEEF in cycle 1 → cycle 2: o_wr_en=1, addr=5, data=0xDEADBEEF; o_pending[5]=1 in cycle 2 and 0 in cycle 3; o_instret=1.
- x0 suppression: push rdest=0, result=0x1234 → o_wr_en stays 0, o_instret increments, o_pending stays 0.
- Load ordering: push load rd=3, then ALU rd=4=0x11; hold i_ld_* idle 5 cycles → no write occurs; ld pulse with 0xCAFE → next cycle writes r3=0xCAFE, following cycle writes r4=0x11.
- Full/backpressure with q_depth_p=4: push 4 loads → o_ex_ready=0; a 5th i_ex_valid is not accepted. One ld pulse, then retire → o_ex_ready=1 in the cycle after the pop. Repeat 3 times to cover pointer wrap.
- Stray load data: i_ld_valid with an empty queue → o_ld_err=1 and no write occurs; o_ld_err stays 1 until rst.
- Reset mid-flight: 3 entries queued, assert rst → o_wr_en=0, o_pending=0, o_instret=0, o_ex_ready=1 immediately; deassert rst and push rd=7 → r7 is written 1 cycle later.

Source files
------------

// File: rtl/regfile_writeback.sv
`default_nettype none
// ============================================================================
// Module   : regfile_writeback
// Purpose  : In-order writeback stage. Queues execute results, merges late
//            load data into the matching entry, retires one entry per cycle
//            to the register file and publishes a pending-write mask.
// Revision : 1.0  initial release
// ============================================================================
module regfile_writeback #(
  parameter int n_regs_p  = 32,
  parameter int wd_regs_p = 32,
  parameter int q_depth_p = 4,
  localparam int AW = $clog2(n_regs_p)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 i_ex_valid,
  output logic                 o_ex_ready,
  input  logic [AW-1:0]        i_ex_rdest,
  input  logic [wd_regs_p-1:0] i_ex_result,
  input  logic                 i_ex_is_load,
  input  logic                 i_ld_valid,
  input  logic [wd_regs_p-1:0] i_ld_data,
  output logic                 o_wr_en,
  output logic [AW-1:0]        o_wr_addr,
  output logic [wd_regs_p-1:0] o_wr_data,
  output logic [n_regs_p-1:0]  o_pending,
  output logic                 o_ld_err,
  output logic [63:0]          o_instret
);

  localparam int QW = $clog2(q_depth_p);
  localparam int PW = QW + 1;

  // Queue storage
  logic [AW-1:0]        rdest_q [q_depth_p];
  logic [AW-1:0]        rdest_d [q_depth_p];
  logic [wd_regs_p-1:0] data_q  [q_depth_p];
  logic [wd_regs_p-1:0] data_d  [q_depth_p];
  logic [q_depth_p-1:0] is_load_q, is_load_d;
  logic [q_depth_p-1:0] data_ok_q, data_ok_d;

  // Pointers carry one extra MSB so full and empty are distinguishable
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW-1:0] ld_ptr_q, ld_ptr_d;

  logic          ld_err_q, ld_err_d;
  logic [63:0]   instret_q, instret_d;

  logic [QW-1:0] w_wr_idx, w_rd_idx, w_ld_idx;
  logic [PW-1:0] w_occ, w_occ_d;
  logic          w_full, w_empty, w_push, w_retire, w_ld_pend, w_fill;
  logic [PW-1:0] w_scan_ptr;
  logic          w_found;

  assign w_wr_idx  = wr_ptr_q[QW-1:0];
  assign w_rd_idx  = rd_ptr_q[QW-1:0];
  assign w_ld_idx  = ld_ptr_q[QW-1:0];
  assign w_occ     = wr_ptr_q - rd_ptr_q;
  assign w_empty   = (wr_ptr_q == rd_ptr_q);
  assign w_full    = (w_wr_idx == w_rd_idx) && (wr_ptr_q[QW] != rd_ptr_q[QW]);
  assign w_push    = i_ex_valid & ~w_full;
  assign w_retire  = ~w_empty & data_ok_q[w_rd_idx];
  // ld_ptr rests on wr_ptr whenever no load is waiting for data
  assign w_ld_pend = (ld_ptr_q != wr_ptr_q);
  assign w_fill    = i_ld_valid & w_ld_pend;

  assign o_ex_ready = ~w_full;
  assign o_wr_en    = w_retire & (rdest_q[w_rd_idx] != '0);
  assign o_wr_addr  = rdest_q[w_rd_idx];
  assign o_wr_data  = data_q[w_rd_idx];
  assign o_ld_err   = ld_err_q;
  assign o_instret  = instret_q;

  // Next-state for queue contents, pointers, error flag and retire counter
  always_comb begin
    rdest_d   = rdest_q;
    data_d    = data_q;
    is_load_d = is_load_q;
    data_ok_d = data_ok_q;

    // The fill target is always an occupied slot; the push target is always
    // free, so both writes can land in the same cycle without conflict.
    if (w_fill) begin
      data_d[w_ld_idx]    = i_ld_data;
      data_ok_d[w_ld_idx] = 1'b1;
    end
    if (w_push) begin
      rdest_d[w_wr_idx]   = i_ex_rdest;
      data_d[w_wr_idx]    = i_ex_is_load ? '0 : i_ex_result;
      is_load_d[w_wr_idx] = i_ex_is_load;
      data_ok_d[w_wr_idx] = ~i_ex_is_load;
    end

    wr_ptr_d = wr_ptr_q + PW'(w_push);
    rd_ptr_d = rd_ptr_q + PW'(w_retire);
    w_occ_d  = wr_ptr_d - rd_ptr_d;

    // Re-aim ld_ptr at the oldest load still waiting, else at wr_ptr
    ld_ptr_d   = wr_ptr_d;
    w_found    = 1'b0;
    w_scan_ptr = rd_ptr_d;
    for (int k = 0; k < q_depth_p; k++) begin
      w_scan_ptr = rd_ptr_d + PW'(k);
      if (!w_found && (PW'(k) < w_occ_d) &&
          is_load_d[w_scan_ptr[QW-1:0]] && !data_ok_d[w_scan_ptr[QW-1:0]]) begin
        ld_ptr_d = w_scan_ptr;
        w_found  = 1'b1;
      end
    end

    ld_err_d  = ld_err_q | (i_ld_valid & ~w_ld_pend);
    instret_d = instret_q + 64'(w_retire);
  end

  // State registers; reset empties the queue immediately
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rdest_q   <= '{default: '0};
      data_q    <= '{default: '0};
      is_load_q <= '0;
      data_ok_q <= '0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      ld_ptr_q  <= '0;
      ld_err_q  <= 1'b0;
      instret_q <= '0;
    end else begin
      rdest_q   <= rdest_d;
      data_q    <= data_d;
      is_load_q <= is_load_d;
      data_ok_q <= data_ok_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      ld_ptr_q  <= ld_ptr_d;
      ld_err_q  <= ld_err_d;
      instret_q <= instret_d;
    end
  end

  // Pending-write mask: one-hot of every occupied entry's destination
  always_comb begin
    logic [QW-1:0] off;
    o_pending = '0;
    off       = '0;
    for (int i = 0; i < q_depth_p; i++) begin
      off = QW'(i) - w_rd_idx;
      if ({1'b0, off} < w_occ) begin
        o_pending[rdest_q[i]] = 1'b1;
      end
    end
    o_pending[0] = 1'b0;
  end

endmodule
`default_nettype wire

// File: tb/tb_regfile_writeback.sv
`default_nettype none
// ============================================================================
// Module   : tb_regfile_writeback
// Purpose  : Self-checking bench for regfile_writeback; directed scenarios
//            plus randomized traffic against a queue-level reference model.
// Revision : 1.0  initial release
// ============================================================================
module tb_regfile_writeback;

  localparam int Q = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        ex_valid = 1'b0;
  logic        ex_ready;
  logic [4:0]  ex_rdest = '0;
  logic [31:0] ex_result = '0;
  logic        ex_is_load = 1'b0;
  logic        ld_valid = 1'b0;
  logic [31:0] ld_data = '0;
  logic        wr_en;
  logic [4:0]  wr_addr;
  logic [31:0] wr_data;
  logic [31:0] pending;
  logic        ld_err;
  logic [63:0] instret;

  int n_checks = 0;
  int n_pass   = 0;

  regfile_writeback #(.n_regs_p(32), .wd_regs_p(32), .q_depth_p(Q)) dut (
    .clk         (clk),
    .rst         (rst),
    .i_ex_valid  (ex_valid),
    .o_ex_ready  (ex_ready),
    .i_ex_rdest  (ex_rdest),
    .i_ex_result (ex_result),
    .i_ex_is_load(ex_is_load),
    .i_ld_valid  (ld_valid),
    .i_ld_data   (ld_data),
    .o_wr_en     (wr_en),
    .o_wr_addr   (wr_addr),
    .o_wr_data   (wr_data),
    .o_pending   (pending),
    .o_ld_err    (ld_err),
    .o_instret   (instret)
  );

  always #5 clk = ~clk;

  // Reference model: in-order list of outstanding ops
  typedef struct {
    logic [4:0]  rd;
    logic [31:0] data;
    bit          is_load;
    bit          ok;
  } ent_t;

  ent_t            mq[$];
  bit              m_err  = 1'b0;
  longint unsigned m_inst = 0;

  function automatic bit m_waiting();
    foreach (mq[i]) if (mq[i].is_load && !mq[i].ok) return 1'b1;
    return 1'b0;
  endfunction

  task automatic model_step();
    bit   ret;
    bit   acc;
    int   j;
    ent_t e;
    ret = (mq.size() > 0) && mq[0].ok;
    acc = ex_valid && (mq.size() < Q);
    if (ld_valid) begin
      j = -1;
      foreach (mq[i]) if (j < 0 && mq[i].is_load && !mq[i].ok) j = i;
      if (j >= 0) begin
        mq[j].data = ld_data;
        mq[j].ok   = 1'b1;
      end else begin
        m_err = 1'b1;
      end
    end
    if (ret) begin
      void'(mq.pop_front());
      m_inst++;
    end
    if (acc) begin
      e.rd = ex_rdest; e.data = ex_result; e.is_load = ex_is_load; e.ok = !ex_is_load;
      mq.push_back(e);
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    model_step();
    @(negedge clk);
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    ex_valid = 1'b0; ld_valid = 1'b0; ex_is_load = 1'b0;
    mq.delete(); m_err = 1'b0; m_inst = 0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic push(input logic [4:0] rd, input logic [31:0] val, input bit is_ld);
    ex_valid = 1'b1; ex_rdest = rd; ex_result = val; ex_is_load = is_ld;
    cycle();
    ex_valid = 1'b0;
  endtask

  task automatic test_reset();
    apply_reset();
    n_checks++; if (ex_ready !== 1'b1) $display("FAIL reset_ready: got %0b want 1", ex_ready); else n_pass++;
    n_checks++; if (wr_en !== 1'b0) $display("FAIL reset_wr_en: got %0b want 0", wr_en); else n_pass++;
    n_checks++; if (wr_addr !== 5'd0 || wr_data !== 32'd0) $display("FAIL reset_wr_addr_data: got %0d/%h want 0/0", wr_addr, wr_data); else n_pass++;
    n_checks++; if (pending !== 32'd0) $display("FAIL reset_pending: got %h want 0", pending); else n_pass++;
    n_checks++; if (ld_err !== 1'b0 || instret !== 64'd0) $display("FAIL reset_err_instret: got %0b/%0d want 0/0", ld_err, instret); else n_pass++;
  endtask

  task automatic test_alu();
    push(5'd5, 32'hDEADBEEF, 1'b0);
    n_checks++; if (wr_en !== 1'b1 || wr_addr !== 5'd5 || wr_data !== 32'hDEADBEEF)
      $display("FAIL alu_write: got en=%0b addr=%0d data=%h want 1/5/deadbeef", wr_en, wr_addr, wr_data); else n_pass++;
    n_checks++; if (pending !== 32'h20) $display("FAIL alu_pending_set: got %h want 00000020", pending); else n_pass++;
    cycle();
    n_checks++; if (wr_en !== 1'b0 || pending !== 32'h0) $display("FAIL alu_after: got en=%0b pend=%h want 0/0", wr_en, pending); else n_pass++;
    n_checks++; if (instret !== 64'd1) $display("FAIL alu_instret: got %0d want 1", instret); else n_pass++;
  endtask

  task automatic test_x0();
    push(5'd0, 32'h1234, 1'b0);
    n_checks++; if (wr_en !== 1'b0 || pending !== 32'h0) $display("FAIL x0_suppress: got en=%0b pend=%h want 0/0", wr_en, pending); else n_pass++;
    cycle();
    n_checks++; if (instret !== 64'd2) $display("FAIL x0_instret: got %0d want 2", instret); else n_pass++;
  endtask

  task automatic test_load_order();
    push(5'd3, 32'h0, 1'b1);
    push(5'd4, 32'h11, 1'b0);
    n_checks++; if (pending !== 32'h18) $display("FAIL ld_pending: got %h want 00000018", pending); else n_pass++;
    for (int i = 0; i < 5; i++) begin
      n_checks++; if (wr_en !== 1'b0) $display("FAIL ld_stall_%0d: got en=%0b want 0", i, wr_en); else n_pass++;
      cycle();
    end
    ld_valid = 1'b1; ld_data = 32'hCAFE;
    cycle();
    ld_valid = 1'b0;
    n_checks++; if (wr_en !== 1'b1 || wr_addr !== 5'd3 || wr_data !== 32'hCAFE)
      $display("FAIL ld_first: got en=%0b addr=%0d data=%h want 1/3/cafe", wr_en, wr_addr, wr_data); else n_pass++;
    cycle();
    n_checks++; if (wr_en !== 1'b1 || wr_addr !== 5'd4 || wr_data !== 32'h11)
      $display("FAIL ld_second: got en=%0b addr=%0d data=%h want 1/4/11", wr_en, wr_addr, wr_data); else n_pass++;
    cycle();
    n_checks++; if (wr_en !== 1'b0 || ex_ready !== 1'b1) $display("FAIL ld_drained: got en=%0b rdy=%0b want 0/1", wr_en, ex_ready); else n_pass++;
  endtask

  task automatic test_full_wrap();
    int guard;
    for (int i = 0; i < Q; i++) push(5'(i + 1), 32'h0, 1'b1);
    n_checks++; if (ex_ready !== 1'b0) $display("FAIL full_ready: got %0b want 0", ex_ready); else n_pass++;
    n_checks++; if (pending !== 32'h1E) $display("FAIL full_pending: got %h want 0000001e", pending); else n_pass++;
    push(5'd9, 32'h99, 1'b0);
    n_checks++; if (ex_ready !== 1'b0 || pending[9] !== 1'b0) $display("FAIL full_reject: got rdy=%0b pend9=%0b want 0/0", ex_ready, pending[9]); else n_pass++;
    for (int rep = 0; rep < 3; rep++) begin
      ld_valid = 1'b1; ld_data = 32'hA000 + 32'(rep);
      cycle();
      ld_valid = 1'b0;
      n_checks++; if (wr_en !== 1'b1 || wr_addr !== 5'(rep + 1) || wr_data !== 32'hA000 + 32'(rep) || ex_ready !== 1'b0)
        $display("FAIL wrap_retire_%0d: got en=%0b addr=%0d data=%h rdy=%0b want 1/%0d/%h/0",
                 rep, wr_en, wr_addr, wr_data, ex_ready, rep + 1, 32'hA000 + 32'(rep)); else n_pass++;
      cycle();
      n_checks++; if (ex_ready !== 1'b1) $display("FAIL wrap_ready_%0d: got %0b want 1", rep, ex_ready); else n_pass++;
      push(5'(10 + rep), 32'h0, 1'b1);
      n_checks++; if (ex_ready !== 1'b0) $display("FAIL wrap_refull_%0d: got %0b want 0", rep, ex_ready); else n_pass++;
    end
    guard = 0;
    while (mq.size() > 0 && guard < 40) begin
      ld_valid = m_waiting(); ld_data = $urandom;
      cycle();
      guard++;
    end
    ld_valid = 1'b0;
    n_checks++; if (guard >= 40 || ex_ready !== 1'b1 || pending !== 32'h0)
      $display("FAIL wrap_drain: got guard=%0d rdy=%0b pend=%h want <40/1/0", guard, ex_ready, pending); else n_pass++;
  endtask

  task automatic test_stray();
    ld_valid = 1'b1; ld_data = 32'h55;
    n_checks++; if (wr_en !== 1'b0) $display("FAIL stray_no_write: got %0b want 0", wr_en); else n_pass++;
    cycle();
    ld_valid = 1'b0;
    n_checks++; if (ld_err !== 1'b1 || wr_en !== 1'b0) $display("FAIL stray_err: got err=%0b en=%0b want 1/0", ld_err, wr_en); else n_pass++;
    push(5'd2, 32'h2, 1'b0);
    cycle();
    n_checks++; if (ld_err !== 1'b1) $display("FAIL stray_sticky: got %0b want 1", ld_err); else n_pass++;
  endtask

  task automatic test_reset_midflight();
    push(5'd1, 32'h0, 1'b1);
    push(5'd2, 32'h22, 1'b0);
    push(5'd3, 32'h33, 1'b0);
    n_checks++; if (wr_en !== 1'b0 || pending !== 32'hE) $display("FAIL mid_queued: got en=%0b pend=%h want 0/0000000e", wr_en, pending); else n_pass++;
    ld_valid = 1'b1; ld_data = 32'h77;
    cycle();
    ld_valid = 1'b0;
    n_checks++; if (wr_en !== 1'b1) $display("FAIL mid_pre_write: got %0b want 1", wr_en); else n_pass++;
    #2 rst = 1'b1;
    #1;
    n_checks++; if (wr_en !== 1'b0 || pending !== 32'h0 || instret !== 64'd0 || ex_ready !== 1'b1 || ld_err !== 1'b0)
      $display("FAIL mid_async_reset: got en=%0b pend=%h inst=%0d rdy=%0b err=%0b want 0/0/0/1/0",
               wr_en, pending, instret, ex_ready, ld_err); else n_pass++;
    mq.delete(); m_err = 1'b0; m_inst = 0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    push(5'd7, 32'h7777, 1'b0);
    n_checks++; if (wr_en !== 1'b1 || wr_addr !== 5'd7 || wr_data !== 32'h7777)
      $display("FAIL mid_post_write: got en=%0b addr=%0d data=%h want 1/7/7777", wr_en, wr_addr, wr_data); else n_pass++;
    cycle();
  endtask

  task automatic test_random();
    logic [31:0] exp_pend;
    bit          exp_wr;
    for (int c = 0; c < 400; c++) begin
      exp_pend = '0;
      foreach (mq[i]) exp_pend[mq[i].rd] = 1'b1;
      exp_pend[0] = 1'b0;
      exp_wr = (mq.size() > 0) && mq[0].ok && (mq[0].rd != 0);
      n_checks++; if (ex_ready !== (mq.size() < Q)) $display("FAIL rnd_ready c%0d: got %0b want %0b", c, ex_ready, mq.size() < Q); else n_pass++;
      n_checks++; if (wr_en !== exp_wr) $display("FAIL rnd_wr_en c%0d: got %0b want %0b", c, wr_en, exp_wr); else n_pass++;
      if (exp_wr) begin
        n_checks++; if (wr_addr !== mq[0].rd || wr_data !== mq[0].data)
          $display("FAIL rnd_wr c%0d: got %0d/%h want %0d/%h", c, wr_addr, wr_data, mq[0].rd, mq[0].data); else n_pass++;
      end
      n_checks++; if (pending !== exp_pend) $display("FAIL rnd_pending c%0d: got %h want %h", c, pending, exp_pend); else n_pass++;
      n_checks++; if (ld_err !== m_err || instret !== m_inst)
        $display("FAIL rnd_err_inst c%0d: got %0b/%0d want %0b/%0d", c, ld_err, instret, m_err, m_inst); else n_pass++;
      ex_valid   = ($urandom_range(0, 9) < 6);
      ex_is_load = ($urandom_range(0, 9) < 4);
      ex_rdest   = 5'($urandom);
      ex_result  = $urandom;
      ld_valid   = m_waiting() ? bit'($urandom_range(0, 1)) : ($urandom_range(0, 49) == 0);
      ld_data    = $urandom;
      cycle();
    end
    ex_valid = 1'b0; ld_valid = 1'b0;
  endtask

  initial begin
    test_reset();
    test_alu();
    test_x0();
    test_load_order();
    test_full_wrap();
    test_stray();
    test_reset_midflight();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
